// File: rtl/data_cache.sv
// Purpose: direct-mapped, write-back, write-allocate data cache between the CPU data port and memory.
// Latency: hits complete in the request cycle; misses respond one cycle after the fill's pmem_resp.
// Backpressure: the CPU holds data_read/data_write until data_resp; one line burst outstanding at a time.
// Ports: clk/rst (async active-low); CPU side data_address/data_read/data_write/
//        data_mem_byte_enable/data_w -> data_r/data_resp; memory side pmem_address/
//        pmem_read/pmem_write/pmem_wdata -> pmem_rdata/pmem_resp.
module data_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  data_address,
    input  logic         data_read,
    input  logic         data_write,
    input  logic [3:0]   data_mem_byte_enable,
    input  logic [31:0]  data_w,
    output logic [31:0]  data_r,
    output logic         data_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t               state;
    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_W-1:0]     tag_arr  [SETS];
    logic [255:0]         line_arr [SETS];
    logic [TAG_W-1:0]     lat_tag;
    logic [S_INDEX-1:0]   lat_idx;

    logic [TAG_W-1:0]     req_tag;
    logic [S_INDEX-1:0]   req_idx;
    logic [2:0]           req_word;
    logic                 req;
    logic                 hit;
    logic                 miss;
    logic                 fill_done;
    logic                 unused_addr;

    assign req_tag     = data_address[31:5+S_INDEX];
    assign req_idx     = data_address[4+S_INDEX:5];
    assign req_word    = data_address[4:2];
    assign unused_addr = ^data_address[1:0];

    assign req  = data_read | data_write;
    // valid_q is cleared asynchronously, so no hit can be reported while rst is low.
    assign hit  = (state == IDLE) && req && valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign miss = (state == IDLE) && req && !hit;
    assign fill_done = (state == FILL) && pmem_resp;

    assign data_resp = hit;
    assign data_r    = hit ? line_arr[req_idx][{req_word, 5'b0} +: 32] : 32'h0;

    // Control state and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            lat_tag      <= '0;
            lat_idx      <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= 32'h0;
            pmem_wdata   <= 256'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && data_write) begin
                        dirty_q[req_idx] <= 1'b1;
                    end else if (miss) begin
                        lat_tag <= req_tag;
                        lat_idx <= req_idx;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_arr[req_idx], req_idx, 5'b0};
                            pmem_wdata   <= line_arr[req_idx];
                        end else begin
                            state        <= FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, req_idx, 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state        <= FILL;
                        pmem_write   <= 1'b0;
                        pmem_wdata   <= 256'h0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {lat_tag, lat_idx, 5'b0};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state            <= IDLE;
                        pmem_read        <= 1'b0;
                        pmem_address     <= 32'h0;
                        valid_q[lat_idx] <= 1'b1;
                        dirty_q[lat_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage need no reset; reset forces state to IDLE so no fill lands.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[lat_idx]  <= lat_tag;
            line_arr[lat_idx] <= pmem_rdata;
        end else if (hit && data_write) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mem_byte_enable[b]) begin
                    line_arr[req_idx][int'({req_word, 5'b0}) + 8*b +: 8] <= data_w[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic         clk;
    logic         rst;
    logic [31:0]  data_address;
    logic         data_read;
    logic         data_write;
    logic [3:0]   data_mem_byte_enable;
    logic [31:0]  data_w;
    logic [31:0]  data_r;
    logic         data_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    data_cache #(.S_INDEX(3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .data_address         (data_address),
        .data_read            (data_read),
        .data_write           (data_write),
        .data_mem_byte_enable (data_mem_byte_enable),
        .data_w               (data_w),
        .data_r               (data_r),
        .data_resp            (data_resp),
        .pmem_address         (pmem_address),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_wdata           (pmem_wdata),
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        presp;
        logic        exp_resp;
        logic        chk_r;
        logic [31:0] exp_r;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        data_read            = rd;
        data_write           = wr;
        data_address         = addr;
        data_mem_byte_enable = be;
        data_w               = wd;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
        return l;
    endfunction

    vec_t         vecs [11];
    logic [255:0] line_a, line_b, line_c, line_d, line_e, exp_wb;

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        line_a = mk_line(32'h1000_0000);
        line_a[63:32] = 32'hDEAD_BEEF;
        line_b = mk_line(32'h2000_0000);
        line_c = mk_line(32'h3000_0000);
        line_d = mk_line(32'h4000_0000);
        line_e = mk_line(32'h5000_0000);

        // Hits on the line at 0x100 after the cold fill.
        vecs[0]  = '{1'b1, 1'b0, 32'h104, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1000_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h11C, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1000_0007};
        vecs[3]  = '{1'b0, 1'b1, 32'h104, 4'h3, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h104, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_5678};
        vecs[5]  = '{1'b1, 1'b1, 32'h108, 4'hF, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h108, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hAABB_CCDD};
        vecs[7]  = '{1'b0, 1'b1, 32'h10C, 4'h8, 32'h1122_3344, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h10C, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1100_0003};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h104, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hDEAD_5678};

        exp_wb = mk_line(32'h1000_0000);
        exp_wb[63:32]  = 32'hDEAD_5678;
        exp_wb[95:64]  = 32'hAABB_CCDD;
        exp_wb[127:96] = 32'h1100_0003;

        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        // Reset held for three cycles: every output low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_resp",  data_resp,    0);
        check("rst_data_r",     data_r,       0);
        check("rst_pmem_read",  pmem_read,    0);
        check("rst_pmem_write", pmem_write,   0);
        check("rst_pmem_addr",  pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata,   0);
        next_cycle();
        rst = 1'b1;

        // Cold read miss at 0x104.
        drive(1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        @(negedge clk);
        check("cold_miss_resp", data_resp, 0);
        check("cold_miss_pread_early", pmem_read, 0);
        next_cycle();
        @(negedge clk);
        check("cold_pread",  pmem_read,    1);
        check("cold_paddr",  pmem_address, 32'h100);
        check("cold_pwrite", pmem_write,   0);
        next_cycle();
        @(negedge clk);
        check("cold_pread_hold", pmem_read, 1);
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = line_a;
        @(negedge clk);
        check("cold_resp_during_fill", data_resp, 0);
        next_cycle();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        check("cold_resp",    data_resp, 1);
        check("cold_data_r",  data_r,    32'hDEAD_BEEF);
        check("cold_pread_off", pmem_read, 0);
        next_cycle();

        // Table of same-cycle hits, masked writes and idle cycles.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd);
            pmem_resp = vecs[i].presp;
            @(negedge clk);
            check($sformatf("vec%0d_resp", i), data_resp, vecs[i].exp_resp);
            if (vecs[i].chk_r) check($sformatf("vec%0d_data_r", i), data_r, vecs[i].exp_r);
            check($sformatf("vec%0d_pread", i),  pmem_read,  0);
            check($sformatf("vec%0d_pwrite", i), pmem_write, 0);
            next_cycle();
        end
        pmem_resp = 1'b0;

        // Dirty eviction: 0x1104 maps onto the dirty line at 0x100.
        drive(1'b1, 1'b0, 32'h1104, 4'h0, 32'h0);
        @(negedge clk);
        check("evict_miss_resp", data_resp, 0);
        next_cycle();
        @(negedge clk);
        check("wb_pwrite", pmem_write,   1);
        check("wb_pread",  pmem_read,    0);
        check("wb_paddr",  pmem_address, 32'h100);
        check("wb_wdata",  pmem_wdata,   exp_wb);
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        check("wb_wdata_hold", pmem_wdata,   exp_wb);
        check("wb_paddr_hold", pmem_address, 32'h100);
        next_cycle();
        pmem_rdata = line_b;
        @(negedge clk);
        check("evict_fill_pread",  pmem_read,    1);
        check("evict_fill_pwrite", pmem_write,   0);
        check("evict_fill_paddr",  pmem_address, 32'h1100);
        check("evict_fill_resp",   data_resp,    0);
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("evict_resp",   data_resp, 1);
        check("evict_data_r", data_r,    32'h2000_0001);
        check("evict_pread_off", pmem_read, 0);
        next_cycle();

        // Write miss allocate at 0x44.
        drive(1'b0, 1'b1, 32'h44, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        check("wmiss_resp", data_resp, 0);
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = line_c;
        @(negedge clk);
        check("wmiss_pread", pmem_read,    1);
        check("wmiss_paddr", pmem_address, 32'h40);
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("wmiss_resp_after_fill", data_resp, 1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        @(negedge clk);
        check("wmiss_reread_resp", data_resp, 1);
        check("wmiss_reread_r",    data_r,    32'hCAFE_F00D);
        next_cycle();
        drive(1'b1, 1'b0, 32'h1044, 4'h0, 32'h0);
        @(negedge clk);
        check("wmiss_evict_miss", data_resp, 0);
        next_cycle();
        exp_wb = line_c;
        exp_wb[63:32] = 32'hCAFE_F00D;
        pmem_resp  = 1'b1;
        pmem_rdata = line_d;
        @(negedge clk);
        check("wmiss_wb_pwrite", pmem_write,   1);
        check("wmiss_wb_paddr",  pmem_address, 32'h40);
        check("wmiss_wb_wdata",  pmem_wdata,   exp_wb);
        next_cycle();
        @(negedge clk);
        check("wmiss_fill_paddr", pmem_address, 32'h1040);
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("wmiss_evict_resp", data_resp, 1);
        check("wmiss_evict_r",    data_r,    32'h4000_0001);
        next_cycle();

        // Reset in the middle of a fill.
        drive(1'b1, 1'b0, 32'h84, 4'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        check("midrst_pread_before", pmem_read, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_pread_async", pmem_read,    0);
        check("midrst_paddr_async", pmem_address, 0);
        check("midrst_resp_async",  data_resp,    0);
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = line_e;
        @(negedge clk);
        check("midrst_pread_held", pmem_read, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_remiss", data_resp, 0);
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("midrst_refill_pread", pmem_read,    1);
        check("midrst_refill_paddr", pmem_address, 32'h80);
        next_cycle();
        pmem_resp = 1'b1;
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("midrst_refill_resp", data_resp, 1);
        check("midrst_refill_r",    data_r,    32'h5000_0001);
        next_cycle();

        // Lines resident before the reset are no longer valid.
        drive(1'b1, 1'b0, 32'h1104, 4'h0, 32'h0);
        @(negedge clk);
        check("postrst_invalid_resp", data_resp, 0);
        next_cycle();
        @(negedge clk);
        check("postrst_pread",  pmem_read,    1);
        check("postrst_pwrite", pmem_write,   0);
        check("postrst_paddr",  pmem_address, 32'h1100);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = line_b;
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("postrst_dropped_no_resp", data_resp, 0);
        check("postrst_pread_off",       pmem_read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
